// File: rtl/bram_wr_arb_pkg.sv
// Shared types and helpers for the BRAM write-port arbiter and its
// reusable two-way round-robin grant block.
package bram_wr_arb_pkg;

    localparam int NUM_PORTS = 2;

    typedef enum logic {
        PORT0 = 1'b0,
        PORT1 = 1'b1
    } port_t;

    // On a tie the port that did not win last time gets the grant.
    function automatic logic [1:0] rr_pick(input logic [1:0] elig, input port_t last);
        logic [1:0] gnt;
        gnt = elig;
        if (elig == 2'b11) begin
            gnt = (last == PORT1) ? 2'b01 : 2'b10;
        end
        return gnt;
    endfunction

endpackage

// File: rtl/bram_wr_arb_rr_arb2.sv
// Two-way round-robin grant with its last-winner register; the grant is
// combinational from the eligibility inputs and only qualified by en.
module rr_arb2
    import bram_wr_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [1:0] elig,
    output logic [1:0] gnt
);

    port_t last_gnt_reg;

    assign gnt = en ? rr_pick(elig, last_gnt_reg) : 2'b00;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_gnt_reg <= PORT1;
        end else if (gnt[0]) begin
            last_gnt_reg <= PORT0;
        end else if (gnt[1]) begin
            last_gnt_reg <= PORT1;
        end
    end

endmodule

// File: rtl/bram_wr_arb.sv
// Shares the BRAM write port between two req/ack requesters and runs a
// full-memory clear sweep on command; all write-port signals are registered.
module bram_wr_arb
    import bram_wr_arb_pkg::*;
#(
    parameter int addr_width = 8,
    parameter int data_width = 12
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr_start,
    input  logic [data_width-1:0] clr_data,
    output logic                  clr_busy,
    output logic                  clr_done,
    input  logic                  req0,
    input  logic [addr_width-1:0] addr0,
    input  logic [data_width-1:0] data0,
    output logic                  ack0,
    input  logic                  req1,
    input  logic [addr_width-1:0] addr1,
    input  logic [data_width-1:0] data1,
    output logic                  ack1,
    output logic                  we,
    output logic [addr_width-1:0] waddr,
    output logic [data_width-1:0] din
);

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    localparam int cnt_width = addr_width + 1;

    state_t                  state_reg, state_next;
    logic [cnt_width-1:0]    cnt_reg, cnt_next;
    logic [data_width-1:0]   fill_reg, fill_next;
    logic                    we_reg, we_next;
    logic [addr_width-1:0]   waddr_reg, waddr_next;
    logic [data_width-1:0]   din_reg, din_next;
    logic [1:0]              ack_reg, ack_next;
    logic                    done_reg, done_next;

    logic [1:0]              req_vec;
    logic [1:0]              elig;
    logic [1:0]              gnt;
    logic                    arb_en;
    logic [addr_width-1:0]   addr_arr [NUM_PORTS];
    logic [data_width-1:0]   data_arr [NUM_PORTS];

    assign req_vec     = {req1, req0};
    assign addr_arr[0] = addr0;
    assign addr_arr[1] = addr1;
    assign data_arr[0] = data0;
    assign data_arr[1] = data1;

    // A port still showing its ack is not eligible, so a held request is
    // never written twice for one handshake.
    for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_elig
        assign elig[gi] = req_vec[gi] & ~ack_reg[gi];
    end

    rr_arb2 u_rr_arb2 (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (arb_en),
        .elig  (elig),
        .gnt   (gnt)
    );

    // cnt_reg holds the next address to clear; the address-0 write is issued
    // on the start edge itself, so the counter leaves that edge at 1 and the
    // MSB marks that the last address has already been written.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        fill_next  = fill_reg;
        we_next    = 1'b0;
        waddr_next = waddr_reg;
        din_next   = din_reg;
        ack_next   = 2'b00;
        done_next  = 1'b0;
        arb_en     = 1'b0;

        case (state_reg)
            IDLE: begin
                if (clr_start) begin
                    state_next = CLEAR;
                    fill_next  = clr_data;
                    we_next    = 1'b1;
                    waddr_next = '0;
                    din_next   = clr_data;
                    cnt_next   = cnt_width'(1);
                end else begin
                    arb_en = 1'b1;
                end
            end
            CLEAR: begin
                if (cnt_reg[addr_width]) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                    done_next  = 1'b1;
                    arb_en     = 1'b1;
                end else begin
                    we_next    = 1'b1;
                    waddr_next = cnt_reg[addr_width-1:0];
                    din_next   = fill_reg;
                    cnt_next   = cnt_reg + cnt_width'(1);
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        if (gnt != 2'b00) begin
            we_next    = 1'b1;
            ack_next   = gnt;
            waddr_next = gnt[1] ? addr_arr[1] : addr_arr[0];
            din_next   = gnt[1] ? data_arr[1] : data_arr[0];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            fill_reg  <= '0;
            we_reg    <= 1'b0;
            waddr_reg <= '0;
            din_reg   <= '0;
            ack_reg   <= 2'b00;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            fill_reg  <= fill_next;
            we_reg    <= we_next;
            waddr_reg <= waddr_next;
            din_reg   <= din_next;
            ack_reg   <= ack_next;
            done_reg  <= done_next;
        end
    end

    assign we       = we_reg;
    assign waddr    = waddr_reg;
    assign din      = din_reg;
    assign ack0     = ack_reg[0];
    assign ack1     = ack_reg[1];
    assign clr_done = done_reg;
    assign clr_busy = (state_reg == CLEAR);

endmodule

// File: tb/tb_bram_wr_arb.sv
// Scoreboard bench for bram_wr_arb: drivers push expected writes per source,
// a negedge monitor pops and compares every BRAM write it observes.
module tb_bram_wr_arb;

    localparam int AW    = 4;
    localparam int DW    = 12;
    localparam int DEPTH = 16;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          clr_start = 1'b0;
    logic [DW-1:0] clr_data = '0;
    logic [1:0]    req = 2'b00;
    logic [AW-1:0] addr [2];
    logic [DW-1:0] data [2];
    logic          clr_busy, clr_done, we;
    logic [1:0]    ack;
    logic [AW-1:0] waddr;
    logic [DW-1:0] din;

    int  checks = 0, errors = 0;
    int  cyc = 0, busy_cnt = 0, done_cnt = 0, done_cyc = -1;
    bit  mon_en = 1'b0;
    wr_t exp0[$], exp1[$], expc[$];
    int  ackc0[$], ackc1[$];
    logic [DW-1:0] mem [DEPTH];

    bram_wr_arb #(.addr_width(AW), .data_width(DW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr_start (clr_start),
        .clr_data  (clr_data),
        .clr_busy  (clr_busy),
        .clr_done  (clr_done),
        .req0      (req[0]),
        .addr0     (addr[0]),
        .data0     (data[0]),
        .ack0      (ack[0]),
        .req1      (req[1]),
        .addr1     (addr[1]),
        .data1     (data[1]),
        .ack1      (ack[1]),
        .we        (we),
        .waddr     (waddr),
        .din       (din)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (we) mem[waddr] <= din;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic note_fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: event not expected (cycle %0d)", name, cyc);
    endtask

    // Monitor: every observed write is matched against the queue of its source.
    always @(negedge clk) begin
        if (mon_en) begin
            if (we) begin
                wr_t e;
                if (ack == 2'b11) begin
                    note_fail("double_ack");
                end else if (ack[0]) begin
                    ackc0.push_back(cyc);
                    if (exp0.size() == 0) note_fail("unexpected_ack0");
                    else begin
                        e = exp0.pop_front();
                        check("p0_waddr", 32'(waddr), 32'(e.addr));
                        check("p0_din", 32'(din), 32'(e.data));
                    end
                end else if (ack[1]) begin
                    ackc1.push_back(cyc);
                    if (exp1.size() == 0) note_fail("unexpected_ack1");
                    else begin
                        e = exp1.pop_front();
                        check("p1_waddr", 32'(waddr), 32'(e.addr));
                        check("p1_din", 32'(din), 32'(e.data));
                    end
                end else begin
                    check("clear_write_busy", 32'(clr_busy), 32'd1);
                    if (expc.size() == 0) note_fail("unexpected_clear_write");
                    else begin
                        e = expc.pop_front();
                        check("clr_waddr", 32'(waddr), 32'(e.addr));
                        check("clr_din", 32'(din), 32'(e.data));
                    end
                end
                $display("cycle %0d: write addr=%0h data=%03h ack=%b busy=%b done=%b",
                         cyc, waddr, din, ack, clr_busy, clr_done);
            end else begin
                check("ack_without_we", 32'(ack), 32'd0);
            end
            if (clr_busy) begin
                busy_cnt++;
                check("busy_implies_we", 32'(we), 32'd1);
            end
            if (clr_done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    // Requester: holds req until ack, then presents the next word at once
    // (gap_max=0) or after a random idle gap.
    task automatic run_port(input int p, input int n, input bit rnd,
                            input logic [AW-1:0] fa, input logic [DW-1:0] fd,
                            input int gap_max);
        int t, g;
        wr_t e;
        @(negedge clk);
        for (int i = 0; i < n; i++) begin
            e.addr  = rnd ? AW'($urandom) : fa;
            e.data  = rnd ? DW'($urandom) : fd;
            addr[p] = e.addr;
            data[p] = e.data;
            req[p]  = 1'b1;
            if (p == 0) exp0.push_back(e);
            else        exp1.push_back(e);
            t = 0;
            do begin
                @(negedge clk);
                t++;
            end while (!ack[p] && t < 300);
            if (!ack[p]) begin
                note_fail("ack_timeout");
                req[p] = 1'b0;
                return;
            end
            if (gap_max > 0) begin
                g = $urandom_range(gap_max, 0);
                if (g > 0) begin
                    req[p] = 1'b0;
                    repeat (g) @(negedge clk);
                end
            end
        end
        req[p] = 1'b0;
    endtask

    task automatic do_clear(input logic [DW-1:0] fill, input bit second);
        int d0, b0, s, t;
        @(negedge clk);
        clr_start = 1'b1;
        clr_data  = fill;
        s  = cyc;
        d0 = done_cnt;
        b0 = busy_cnt;
        for (int a = 0; a < DEPTH; a++) expc.push_back('{addr: AW'(a), data: fill});
        @(negedge clk);
        clr_start = 1'b0;
        clr_data  = DW'($urandom);
        if (second) begin
            repeat (5) @(negedge clk);
            clr_start = 1'b1;
            clr_data  = ~fill;
            @(negedge clk);
            clr_start = 1'b0;
        end
        t = 0;
        while (done_cnt == d0 && t < 100) begin
            @(negedge clk);
            #1;
            t++;
        end
        check("clr_done_seen", 32'(done_cnt - d0), 32'd1);
        check("clr_done_cycle", 32'(done_cyc), 32'(s + DEPTH + 1));
        check("clr_busy_cycles", 32'(busy_cnt - b0), 32'(DEPTH));
        check("clr_queue_drained", 32'(expc.size()), 32'd0);
        for (int a = 0; a < DEPTH; a++) check("clear_readback", 32'(mem[a]), 32'(fill));
        @(negedge clk);
        #1;
        check("clr_done_single", 32'(done_cnt - d0), 32'd1);
        check("clr_busy_low", 32'(clr_busy), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int s, d0;
        addr[0] = '0; addr[1] = '0; data[0] = '0; data[1] = '0;

        // Reset with both requests pending, then contention from release.
        fork
            begin
                repeat (3) begin
                    @(negedge clk);
                    check("rst_we", 32'(we), 32'd0);
                    check("rst_ack", 32'(ack), 32'd0);
                    check("rst_busy", 32'(clr_busy), 32'd0);
                end
                check("rst_waddr", 32'(waddr), 32'd0);
                check("rst_din", 32'(din), 32'd0);
                check("rst_done", 32'(clr_done), 32'd0);
                mon_en = 1'b1;
                rst_n  = 1'b1;
            end
            run_port(0, 4, 1'b0, 4'd1, 12'h111, 0);
            run_port(1, 4, 1'b0, 4'd2, 12'h222, 0);
        join
        repeat (2) @(negedge clk);
        check("cont_acks0", 32'(ackc0.size()), 32'd4);
        check("cont_acks1", 32'(ackc1.size()), 32'd4);
        if (ackc0.size() == 4 && ackc1.size() == 4) begin
            check("first_grant_port0", 32'(ackc0[0] < ackc1[0]), 32'd1);
            for (int i = 0; i < 4; i++) check("alternate_p1_after_p0", 32'(ackc1[i] - ackc0[i]), 32'd1);
            for (int i = 0; i < 3; i++) check("alternate_p0_period", 32'(ackc0[i+1] - ackc0[i]), 32'd2);
        end
        check("readback_addr1", 32'(mem[1]), 32'h111);
        check("readback_addr2", 32'(mem[2]), 32'h222);

        // Single requester: one write every second cycle.
        ackc0.delete(); ackc1.delete();
        run_port(0, 4, 1'b0, 4'd3, 12'hABC, 0);
        repeat (2) @(negedge clk);
        check("single_acks0", 32'(ackc0.size()), 32'd4);
        check("single_no_ack1", 32'(ackc1.size()), 32'd0);
        if (ackc0.size() == 4)
            for (int i = 0; i < 3; i++) check("single_period", 32'(ackc0[i+1] - ackc0[i]), 32'd2);
        check("readback_addr3", 32'(mem[3]), 32'hABC);

        // Plain clear sweep.
        do_clear(12'h5A5, 1'b0);

        // Clear with a held request and a stray mid-sweep clr_start.
        ackc0.delete(); ackc1.delete();
        fork
            run_port(1, 1, 1'b1, '0, '0, 0);
            do_clear(12'hC3C, 1'b1);
        join
        check("held_req_ack_count", 32'(ackc1.size()), 32'd1);
        if (ackc1.size() == 1) check("held_req_ack_at_done", 32'(ackc1[0]), 32'(done_cyc));

        // Reset at the 6th clear write, then a fresh sweep from address 0.
        @(negedge clk);
        clr_start = 1'b1;
        clr_data  = 12'h3C3;
        s  = cyc;
        d0 = done_cnt;
        for (int a = 0; a < DEPTH; a++) expc.push_back('{addr: AW'(a), data: 12'h3C3});
        @(negedge clk);
        clr_start = 1'b0;
        repeat (5) @(negedge clk);
        #1;
        check("sixth_clear_cycle", 32'(cyc), 32'(s + 6));
        check("sixth_clear_addr", 32'(waddr), 32'd5);
        rst_n = 1'b0;
        expc.delete();
        @(negedge clk);
        check("midrst_we", 32'(we), 32'd0);
        check("midrst_busy", 32'(clr_busy), 32'd0);
        check("midrst_done", 32'(clr_done), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("midrst_no_done", 32'(done_cnt - d0), 32'd0);
        do_clear(12'h0F0, 1'b0);

        // Random traffic on both ports with a clear dropped in the middle.
        fork
            run_port(0, 25, 1'b1, '0, '0, 3);
            run_port(1, 25, 1'b1, '0, '0, 3);
            begin
                repeat ($urandom_range(30, 10)) @(negedge clk);
                do_clear(DW'($urandom), 1'b0);
            end
        join
        repeat (3) @(negedge clk);
        check("exp0_drained", 32'(exp0.size()), 32'd0);
        check("exp1_drained", 32'(exp1.size()), 32'd0);
        check("expc_drained", 32'(expc.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
